// File: rtl/hs4_pkg.sv
// Shared types and sizing helpers for the 4-phase bundled-data transmitter.
package hs4_pkg;

    typedef enum logic [2:0] {
        RECOVER,
        IDLE,
        SETUP,
        WAIT_ACK_HI,
        WAIT_ACK_LO
    } hs4_state_t;

    localparam int SENT_W = 16;

    // Width of a counter that must be able to hold the value TIMEOUT itself.
    function automatic int tmo_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/hs4_async_tx_if.sv
// Sync-side push port plus the 4-phase req/ack/data bundle toward the async pipeline.
interface hs4_async_tx_if #(parameter int DATA_W = 8);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              req_out;
    logic [DATA_W-1:0] data_out;
    logic              ack_in;

    // master: the transmitter; slave: the sync producer plus the async consumer
    modport master (
        input  in_valid, in_data, ack_in,
        output in_ready, req_out, data_out
    );
    modport slave (
        output in_valid, in_data, ack_in,
        input  in_ready, req_out, data_out
    );
endinterface

// File: rtl/hs4_sync.sv
// Multi-flop synchronizer for a single asynchronous level.
// Latency: STAGES clk edges.
// No backpressure; samples every cycle.
module hs4_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) chain <= '0;
        else       chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/hs4_async_tx.sv
// Pushes FIFO-buffered clk-domain words into a 4-phase bundled-data async pipeline.
// Latency: push to data_out 1 edge, data_out to req_out SETUP_CYCLES edges, plus ack sync.
// Backpressure: in_ready drops when the FIFO is full; ack waits never abort.
module hs4_async_tx
    import hs4_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int SETUP_CYCLES = 1,
    parameter int TIMEOUT      = 255
) (
    input  logic              clk,
    input  logic              reset,
    hs4_async_tx_if.master    bus,
    output logic              busy,
    output logic              timeout_err,
    output logic [SENT_W-1:0] sent_count
);

    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int TMO_W  = tmo_width(TIMEOUT);
    localparam int SET_W  = $clog2(SETUP_CYCLES + 1);
    localparam int FILL_W = $clog2(SYNC_STAGES + 1);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       fifo_cnt;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    hs4_state_t        state;
    logic              req_q;
    logic [DATA_W-1:0] data_q;
    logic [SET_W-1:0]  setup_cnt;
    logic [FILL_W-1:0] fill_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              timeout_q;
    logic [SENT_W-1:0] sent_q;
    logic              ack_s;

    hs4_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.ack_in),
        .q     (ack_s)
    );

    assign full  = (fifo_cnt == (AW+1)'(FIFO_DEPTH));
    assign empty = (fifo_cnt == '0);
    assign push  = bus.in_valid && !full;
    assign pop   = (state == IDLE) && !empty;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.in_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // The synchronizer is cleared by reset, so RECOVER first lets it fill with the
    // live ack level before trusting ack_s==0 as "async side has released".
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RECOVER;
            req_q     <= 1'b0;
            data_q    <= '0;
            setup_cnt <= '0;
            fill_cnt  <= '0;
            tmo_cnt   <= '0;
            timeout_q <= 1'b0;
            sent_q    <= '0;
        end else begin
            case (state)
                RECOVER: begin
                    if (fill_cnt != FILL_W'(SYNC_STAGES)) fill_cnt <= fill_cnt + 1'b1;
                    else if (!ack_s)                      state    <= IDLE;
                end
                IDLE: begin
                    if (!empty) begin
                        data_q    <= mem[rd_ptr];
                        setup_cnt <= '0;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    if (setup_cnt == SET_W'(SETUP_CYCLES - 1)) begin
                        req_q   <= 1'b1;
                        tmo_cnt <= '0;
                        state   <= WAIT_ACK_HI;
                    end else begin
                        setup_cnt <= setup_cnt + 1'b1;
                    end
                end
                WAIT_ACK_HI: begin
                    if (ack_s) begin
                        req_q   <= 1'b0;
                        tmo_cnt <= '0;
                        state   <= WAIT_ACK_LO;
                    end else if (tmo_cnt != TMO_W'(TIMEOUT)) begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                        if (tmo_cnt == TMO_W'(TIMEOUT - 1)) timeout_q <= 1'b1;
                    end
                end
                WAIT_ACK_LO: begin
                    if (!ack_s) begin
                        sent_q <= sent_q + 1'b1;
                        state  <= IDLE;
                    end else if (tmo_cnt != TMO_W'(TIMEOUT)) begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                        if (tmo_cnt == TMO_W'(TIMEOUT - 1)) timeout_q <= 1'b1;
                    end
                end
                default: state <= RECOVER;
            endcase
        end
    end

    assign bus.in_ready = !full;
    assign bus.req_out  = req_q;
    assign bus.data_out = data_q;
    assign busy         = (state != IDLE) || !empty;
    assign timeout_err  = timeout_q;
    assign sent_count   = sent_q;

endmodule
